// File: rtl/icb_buffer.sv
// icb_buffer: registered ICB buffer stage between an ICB master (s_ side)
// and the ICB-to-APB bridge (m_ side). Commands and responses each pass
// through a small FIFO; the number of transactions accepted upstream but
// not yet answered upstream is capped at OUTS_MAX. A downstream response
// arriving with nothing pending raises a sticky orphan_err flag.
module icb_buffer #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CMD_DEPTH = 2,
  parameter int RSP_DEPTH = 2,
  parameter int OUTS_MAX  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_icb_cmd_valid,
  output logic                s_icb_cmd_ready,
  input  logic [ADDR_W-1:0]   s_icb_cmd_addr,
  input  logic                s_icb_cmd_read,
  input  logic [DATA_W-1:0]   s_icb_cmd_wdata,
  input  logic [DATA_W/8-1:0] s_icb_cmd_wmask,
  output logic                s_icb_rsp_valid,
  input  logic                s_icb_rsp_ready,
  output logic [DATA_W-1:0]   s_icb_rsp_rdata,
  output logic                s_icb_rsp_err,
  output logic                m_icb_cmd_valid,
  input  logic                m_icb_cmd_ready,
  output logic [ADDR_W-1:0]   m_icb_cmd_addr,
  output logic                m_icb_cmd_read,
  output logic [DATA_W-1:0]   m_icb_cmd_wdata,
  output logic [DATA_W/8-1:0] m_icb_cmd_wmask,
  input  logic                m_icb_rsp_valid,
  output logic                m_icb_rsp_ready,
  input  logic [DATA_W-1:0]   m_icb_rsp_rdata,
  input  logic                m_icb_rsp_err,
  output logic                orphan_err
);

  localparam int MW  = DATA_W / 8;
  localparam int CPW = $clog2(CMD_DEPTH);
  localparam int CCW = $clog2(CMD_DEPTH + 1);
  localparam int RPW = $clog2(RSP_DEPTH);
  localparam int RCW = $clog2(RSP_DEPTH + 1);
  localparam int OCW = $clog2(OUTS_MAX + 1);

  localparam logic [CCW-1:0] CMD_FULL = CCW'(CMD_DEPTH);
  localparam logic [RCW-1:0] RSP_FULL = RCW'(RSP_DEPTH);
  localparam logic [OCW-1:0] OUTS_CAP = OCW'(OUTS_MAX);

  // command FIFO storage and pointers
  logic [ADDR_W-1:0] cmd_addr_q  [CMD_DEPTH];
  logic              cmd_read_q  [CMD_DEPTH];
  logic [DATA_W-1:0] cmd_wdata_q [CMD_DEPTH];
  logic [MW-1:0]     cmd_wmask_q [CMD_DEPTH];
  logic [CPW-1:0]    cmd_wr_ptr;
  logic [CPW-1:0]    cmd_rd_ptr;
  logic [CCW-1:0]    cmd_cnt;

  // response FIFO storage and pointers
  logic [DATA_W-1:0] rsp_rdata_q [RSP_DEPTH];
  logic              rsp_err_q   [RSP_DEPTH];
  logic [RPW-1:0]    rsp_wr_ptr;
  logic [RPW-1:0]    rsp_rd_ptr;
  logic [RCW-1:0]    rsp_cnt;

  logic [OCW-1:0]    outs_cnt;
  logic [OCW-1:0]    pend_cnt;

  logic s_cmd_hs;
  logic m_cmd_hs;
  logic m_rsp_hs;
  logic s_rsp_hs;
  logic orphan_hit;

  // Ready/valid derived from state only; everything is held quiet while rst
  // is high so no handshake can complete in the reset cycle.
  always_comb begin
    s_icb_cmd_ready = !rst && (cmd_cnt < CMD_FULL) && (outs_cnt < OUTS_CAP);
    m_icb_rsp_ready = !rst && (rsp_cnt < RSP_FULL);
    m_icb_cmd_valid = !rst && (cmd_cnt != '0);
    s_icb_rsp_valid = !rst && (rsp_cnt != '0);
    m_icb_cmd_addr  = rst ? '0 : cmd_addr_q[cmd_rd_ptr];
    m_icb_cmd_read  = rst ? 1'b0 : cmd_read_q[cmd_rd_ptr];
    m_icb_cmd_wdata = rst ? '0 : cmd_wdata_q[cmd_rd_ptr];
    m_icb_cmd_wmask = rst ? '0 : cmd_wmask_q[cmd_rd_ptr];
    s_icb_rsp_rdata = rst ? '0 : rsp_rdata_q[rsp_rd_ptr];
    s_icb_rsp_err   = rst ? 1'b0 : rsp_err_q[rsp_rd_ptr];
  end

  // Handshake strobes and orphan detection (a same-cycle downstream command
  // handshake covers a response arriving while pend_cnt is still 0).
  always_comb begin
    s_cmd_hs   = s_icb_cmd_valid && s_icb_cmd_ready;
    m_cmd_hs   = m_icb_cmd_valid && m_icb_cmd_ready;
    m_rsp_hs   = m_icb_rsp_valid && m_icb_rsp_ready;
    s_rsp_hs   = s_icb_rsp_valid && s_icb_rsp_ready;
    orphan_hit = m_rsp_hs && (pend_cnt == '0) && !m_cmd_hs;
  end

  // Command FIFO: push on upstream handshake, pop on downstream handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CMD_DEPTH; i++) begin
        cmd_addr_q[i]  <= '0;
        cmd_read_q[i]  <= 1'b0;
        cmd_wdata_q[i] <= '0;
        cmd_wmask_q[i] <= '0;
      end
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_cnt    <= '0;
    end else begin
      if (s_cmd_hs) begin
        cmd_addr_q[cmd_wr_ptr]  <= s_icb_cmd_addr;
        cmd_read_q[cmd_wr_ptr]  <= s_icb_cmd_read;
        cmd_wdata_q[cmd_wr_ptr] <= s_icb_cmd_wdata;
        cmd_wmask_q[cmd_wr_ptr] <= s_icb_cmd_wmask;
        cmd_wr_ptr              <= cmd_wr_ptr + 1'b1;
      end
      if (m_cmd_hs) begin
        cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
      end
      case ({s_cmd_hs, m_cmd_hs})
        2'b10:   cmd_cnt <= cmd_cnt + 1'b1;
        2'b01:   cmd_cnt <= cmd_cnt - 1'b1;
        default: cmd_cnt <= cmd_cnt;
      endcase
    end
  end

  // Response FIFO: push {rdata, err} from downstream, pop on upstream handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        rsp_rdata_q[i] <= '0;
        rsp_err_q[i]   <= 1'b0;
      end
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
      rsp_cnt    <= '0;
    end else begin
      if (m_rsp_hs) begin
        rsp_rdata_q[rsp_wr_ptr] <= m_icb_rsp_rdata;
        rsp_err_q[rsp_wr_ptr]   <= m_icb_rsp_err;
        rsp_wr_ptr              <= rsp_wr_ptr + 1'b1;
      end
      if (s_rsp_hs) begin
        rsp_rd_ptr <= rsp_rd_ptr + 1'b1;
      end
      case ({m_rsp_hs, s_rsp_hs})
        2'b10:   rsp_cnt <= rsp_cnt + 1'b1;
        2'b01:   rsp_cnt <= rsp_cnt - 1'b1;
        default: rsp_cnt <= rsp_cnt;
      endcase
    end
  end

  // Upstream outstanding count. An orphan response popped upstream must not
  // wrap the counter, so the decrement is suppressed at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      outs_cnt <= '0;
    end else begin
      case ({s_cmd_hs, s_rsp_hs})
        2'b10:   outs_cnt <= outs_cnt + 1'b1;
        2'b01:   outs_cnt <= (outs_cnt != '0) ? outs_cnt - 1'b1 : outs_cnt;
        default: outs_cnt <= outs_cnt;
      endcase
    end
  end

  // Downstream pending count; an orphan response leaves it at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_cnt <= '0;
    end else begin
      case ({m_cmd_hs, m_rsp_hs})
        2'b10:   pend_cnt <= pend_cnt + 1'b1;
        2'b01:   pend_cnt <= (pend_cnt != '0) ? pend_cnt - 1'b1 : pend_cnt;
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

  // Sticky orphan flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      orphan_err <= 1'b0;
    end else if (orphan_hit) begin
      orphan_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_icb_buffer.sv
// Directed testbench for icb_buffer with default parameters.
module tb_icb_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_icb_cmd_valid;
  logic        s_icb_cmd_ready;
  logic [31:0] s_icb_cmd_addr;
  logic        s_icb_cmd_read;
  logic [31:0] s_icb_cmd_wdata;
  logic [3:0]  s_icb_cmd_wmask;
  logic        s_icb_rsp_valid;
  logic        s_icb_rsp_ready;
  logic [31:0] s_icb_rsp_rdata;
  logic        s_icb_rsp_err;
  logic        m_icb_cmd_valid;
  logic        m_icb_cmd_ready;
  logic [31:0] m_icb_cmd_addr;
  logic        m_icb_cmd_read;
  logic [31:0] m_icb_cmd_wdata;
  logic [3:0]  m_icb_cmd_wmask;
  logic        m_icb_rsp_valid;
  logic        m_icb_rsp_ready;
  logic [31:0] m_icb_rsp_rdata;
  logic        m_icb_rsp_err;
  logic        orphan_err;

  int vectors = 0;
  int miscompares = 0;

  icb_buffer dut (
    .clk             (clk),
    .rst             (rst),
    .s_icb_cmd_valid (s_icb_cmd_valid),
    .s_icb_cmd_ready (s_icb_cmd_ready),
    .s_icb_cmd_addr  (s_icb_cmd_addr),
    .s_icb_cmd_read  (s_icb_cmd_read),
    .s_icb_cmd_wdata (s_icb_cmd_wdata),
    .s_icb_cmd_wmask (s_icb_cmd_wmask),
    .s_icb_rsp_valid (s_icb_rsp_valid),
    .s_icb_rsp_ready (s_icb_rsp_ready),
    .s_icb_rsp_rdata (s_icb_rsp_rdata),
    .s_icb_rsp_err   (s_icb_rsp_err),
    .m_icb_cmd_valid (m_icb_cmd_valid),
    .m_icb_cmd_ready (m_icb_cmd_ready),
    .m_icb_cmd_addr  (m_icb_cmd_addr),
    .m_icb_cmd_read  (m_icb_cmd_read),
    .m_icb_cmd_wdata (m_icb_cmd_wdata),
    .m_icb_cmd_wmask (m_icb_cmd_wmask),
    .m_icb_rsp_valid (m_icb_rsp_valid),
    .m_icb_rsp_ready (m_icb_rsp_ready),
    .m_icb_rsp_rdata (m_icb_rsp_rdata),
    .m_icb_rsp_err   (m_icb_rsp_err),
    .orphan_err      (orphan_err)
  );

  always #5 clk = ~clk;

  // advance one clock and sample 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    s_icb_cmd_valid = 1'b1;
    s_icb_cmd_addr  = 32'h99;
    s_icb_cmd_read  = 1'b0;
    s_icb_cmd_wdata = 32'h0;
    s_icb_cmd_wmask = 4'h0;
    s_icb_rsp_ready = 1'b0;
    m_icb_cmd_ready = 1'b0;
    m_icb_rsp_valid = 1'b0;
    m_icb_rsp_rdata = 32'h0;
    m_icb_rsp_err   = 1'b0;

    // reset with a command offered: nothing may be accepted
    #1;
    chk("rst_s_cmd_ready", s_icb_cmd_ready, 0);
    chk("rst_m_rsp_ready", m_icb_rsp_ready, 0);
    chk("rst_m_cmd_valid", m_icb_cmd_valid, 0);
    tick();
    rst = 1'b0;
    s_icb_cmd_valid = 1'b0;
    #1;
    chk("idle_s_cmd_ready", s_icb_cmd_ready, 1);
    chk("idle_m_cmd_valid", m_icb_cmd_valid, 0);
    chk("idle_s_rsp_valid", s_icb_rsp_valid, 0);
    chk("idle_orphan", orphan_err, 0);
    chk("idle_m_rsp_ready", m_icb_rsp_ready, 1);
    chk("idle_m_addr", m_icb_cmd_addr, 0);

    // single write
    s_icb_cmd_valid = 1'b1;
    s_icb_cmd_addr  = 32'h10;
    s_icb_cmd_read  = 1'b0;
    s_icb_cmd_wdata = 32'hDEADBEEF;
    s_icb_cmd_wmask = 4'hF;
    #1;
    chk("wr_no_bypass", m_icb_cmd_valid, 0);
    tick();
    s_icb_cmd_valid = 1'b0;
    s_icb_cmd_addr  = 32'h0;
    s_icb_cmd_wdata = 32'h0;
    s_icb_cmd_wmask = 4'h0;
    #1;
    chk("wr_m_valid", m_icb_cmd_valid, 1);
    chk("wr_m_addr", m_icb_cmd_addr, 32'h10);
    chk("wr_m_wdata", m_icb_cmd_wdata, 32'hDEADBEEF);
    chk("wr_m_wmask", m_icb_cmd_wmask, 4'hF);
    chk("wr_m_read", m_icb_cmd_read, 0);
    m_icb_cmd_ready = 1'b1;
    tick();
    m_icb_cmd_ready = 1'b0;
    chk("wr_m_valid_popped", m_icb_cmd_valid, 0);
    m_icb_rsp_valid = 1'b1;
    m_icb_rsp_rdata = 32'h1234;
    m_icb_rsp_err   = 1'b0;
    #1;
    chk("wr_rsp_latency", s_icb_rsp_valid, 0);
    tick();
    m_icb_rsp_valid = 1'b0;
    #1;
    chk("wr_s_rsp_valid", s_icb_rsp_valid, 1);
    chk("wr_s_rsp_rdata", s_icb_rsp_rdata, 32'h1234);
    chk("wr_s_rsp_err", s_icb_rsp_err, 0);
    chk("wr_orphan", orphan_err, 0);
    s_icb_rsp_ready = 1'b1;
    tick();
    s_icb_rsp_ready = 1'b0;
    chk("wr_s_rsp_popped", s_icb_rsp_valid, 0);

    // backpressure: three back-to-back reads with downstream stalled
    s_icb_cmd_valid = 1'b1;
    s_icb_cmd_read  = 1'b1;
    s_icb_cmd_addr  = 32'h0;
    tick();
    s_icb_cmd_addr = 32'h4;
    chk("bp_ready_after1", s_icb_cmd_ready, 1);
    tick();
    s_icb_cmd_addr = 32'h8;
    #1;
    chk("bp_ready_full", s_icb_cmd_ready, 0);
    chk("bp_head_0", m_icb_cmd_addr, 32'h0);
    tick();
    chk("bp_stall_ready", s_icb_cmd_ready, 0);
    chk("bp_stall_head", m_icb_cmd_addr, 32'h0);
    chk("bp_stall_read", m_icb_cmd_read, 1);
    m_icb_cmd_ready = 1'b1;
    tick();
    chk("bp_head_4", m_icb_cmd_addr, 32'h4);
    chk("bp_ready_after_pop", s_icb_cmd_ready, 1);
    tick();
    s_icb_cmd_valid = 1'b0;
    chk("bp_head_8", m_icb_cmd_addr, 32'h8);
    chk("bp_valid_8", m_icb_cmd_valid, 1);
    tick();
    m_icb_cmd_ready = 1'b0;
    chk("bp_drained", m_icb_cmd_valid, 0);

    // three responses, returned in order while popped continuously
    m_icb_rsp_valid = 1'b1;
    s_icb_rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_icb_rsp_rdata = 32'hA0 + i;
      tick();
      chk("bp_rsp_order", s_icb_rsp_rdata, 32'hA0 + i);
    end
    m_icb_rsp_valid = 1'b0;
    tick();
    s_icb_rsp_ready = 1'b0;
    chk("bp_rsp_empty", s_icb_rsp_valid, 0);

    // outstanding cap
    m_icb_cmd_ready = 1'b1;
    s_icb_cmd_valid = 1'b1;
    s_icb_cmd_read  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_icb_cmd_addr = 32'h100 + 4 * i;
      tick();
    end
    s_icb_cmd_addr = 32'h200;
    chk("cap_ready_0", s_icb_cmd_ready, 0);
    tick();
    chk("cap_still_0", s_icb_cmd_ready, 0);
    chk("cap_m_empty", m_icb_cmd_valid, 0);
    m_icb_rsp_valid = 1'b1;
    m_icb_rsp_rdata = 32'hB0;
    tick();
    m_icb_rsp_valid = 1'b0;
    chk("cap_rsp_valid", s_icb_rsp_valid, 1);
    chk("cap_ready_before_pop", s_icb_cmd_ready, 0);
    s_icb_rsp_ready = 1'b1;
    tick();
    s_icb_cmd_valid = 1'b0;
    s_icb_rsp_ready = 1'b0;
    chk("cap_ready_1", s_icb_cmd_ready, 1);
    m_icb_cmd_ready = 1'b0;
    m_icb_rsp_valid = 1'b1;
    s_icb_rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_icb_rsp_rdata = 32'hB1 + i;
      tick();
    end
    m_icb_rsp_valid = 1'b0;
    tick();
    s_icb_rsp_ready = 1'b0;
    chk("cap_drained", s_icb_rsp_valid, 0);

    // orphan response
    chk("orph_before", orphan_err, 0);
    m_icb_rsp_valid = 1'b1;
    m_icb_rsp_rdata = 32'h55;
    m_icb_rsp_err   = 1'b0;
    tick();
    m_icb_rsp_valid = 1'b0;
    chk("orph_set", orphan_err, 1);
    chk("orph_rsp_valid", s_icb_rsp_valid, 1);
    chk("orph_rsp_rdata", s_icb_rsp_rdata, 32'h55);
    tick();
    chk("orph_sticky", orphan_err, 1);
    s_icb_rsp_ready = 1'b1;
    tick();
    s_icb_rsp_ready = 1'b0;
    chk("orph_outs_no_wrap", s_icb_cmd_ready, 1);
    chk("orph_sticky2", orphan_err, 1);

    // reset mid-burst
    s_icb_cmd_valid = 1'b1;
    s_icb_cmd_read  = 1'b0;
    s_icb_cmd_addr  = 32'h30;
    tick();
    s_icb_cmd_addr = 32'h34;
    tick();
    s_icb_cmd_valid = 1'b0;
    m_icb_rsp_valid = 1'b1;
    m_icb_rsp_rdata = 32'h77;
    m_icb_rsp_err   = 1'b1;
    tick();
    m_icb_rsp_valid = 1'b0;
    m_icb_rsp_err   = 1'b0;
    chk("mid_m_valid", m_icb_cmd_valid, 1);
    chk("mid_m_addr", m_icb_cmd_addr, 32'h30);
    chk("mid_rsp_err", s_icb_rsp_err, 1);
    rst             = 1'b1;
    s_icb_cmd_valid = 1'b1;
    s_icb_cmd_addr  = 32'h99;
    m_icb_cmd_ready = 1'b1;
    s_icb_rsp_ready = 1'b1;
    #1;
    chk("mid_rst_m_valid", m_icb_cmd_valid, 0);
    chk("mid_rst_s_rsp_valid", s_icb_rsp_valid, 0);
    chk("mid_rst_s_ready", s_icb_cmd_ready, 0);
    tick();
    rst             = 1'b0;
    s_icb_cmd_valid = 1'b0;
    m_icb_cmd_ready = 1'b0;
    s_icb_rsp_ready = 1'b0;
    #1;
    chk("post_m_valid", m_icb_cmd_valid, 0);
    chk("post_s_rsp_valid", s_icb_rsp_valid, 0);
    chk("post_orphan", orphan_err, 0);
    chk("post_m_addr", m_icb_cmd_addr, 0);
    chk("post_rsp_rdata", s_icb_rsp_rdata, 0);
    s_icb_cmd_valid = 1'b1;
    s_icb_cmd_addr  = 32'h20;
    tick();
    s_icb_cmd_valid = 1'b0;
    chk("post_first_valid", m_icb_cmd_valid, 1);
    chk("post_first_addr", m_icb_cmd_addr, 32'h20);
    m_icb_cmd_ready = 1'b1;
    tick();
    m_icb_cmd_ready = 1'b0;
    chk("post_only_one", m_icb_cmd_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
